traffic_controller: RTL and testbench
=====================================

TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

Interface
REQ-001 Parameter GREEN_CYCLES, default 8: cycles spent in each green phase; legal range 1..255.
REQ-002 Parameter YELLOW_CYCLES, default 2: cycles spent in each yellow phase; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 res_n  input  1  reset, asynchronous, active-high (asserted when 1).
REQ-005 en  input  1  run enable: 1 = phases advance, 0 = hold/load.
REQ-006 cur_state  input  2  requested phase, loaded while en=0 (see REQ-013).
REQ-007 next_state  output  2  combinational value the phase register takes at the next rising edge.
REQ-008 o  output  4  registered light drive: o[3]=NS green, o[2]=NS yellow, o[1]=EW green, o[0]=EW yellow; a direction is red when neither of its bits is set.

Function
REQ-009 Phase register st (2 bits) encodes four phases: 00 NS_GREEN, 01 NS_YELLOW, 10 EW_GREEN, 11 EW_YELLOW.
REQ-010 Phase order is fixed: 00 -> 01 -> 10 -> 11 -> 00 (wrap after 11).
REQ-011 Dwell counter cnt (8 bits) counts cycles in the current phase; duration is GREEN_CYCLES for 00/10 and YELLOW_CYCLES for 01/11.
REQ-012 en=1 at a rising edge: if cnt == duration-1, st advances one phase and cnt clears to 0; otherwise cnt increments and st holds.
REQ-013 en=0 at a rising edge: behaviour per Configuration (load or hold); cnt never increments while en=0.
REQ-014 o is a pure one-hot decode of st: 00->1000, 01->0100, 10->0010, 11->0001; never any other value.
REQ-015 next_state equals the st value the REQ-012/REQ-013 rules produce from the current st, cnt, en and cur_state; it ignores res_n.
REQ-016 Toggling en from 0 to 1 resumes counting from the current cnt (0 after a load).
REQ-017 Duration 1: the phase advances on every enabled edge.
REQ-018 cur_state changes while en=1 have no effect on st, cnt or o.

Reset
REQ-019 res_n=1 immediately (asynchronously) forces st=00 and cnt=0, so o=1000 without waiting for a clock edge.
REQ-020 Reset has priority over en and cur_state; the first enabled edge after res_n falls counts cycle 1 of NS_GREEN.
REQ-021 Reset asserted mid-phase discards the partial dwell count.

Configuration
REQ-022 Macro TRAFFIC_CTRL_LOAD_EN defined: with en=0, each rising edge loads st <= cur_state and clears cnt to 0.
REQ-023 Macro TRAFFIC_CTRL_LOAD_EN undefined: with en=0, st and cnt hold; cur_state is unused, and next_state = st while en=0.

Structure
REQ-024 Package traffic_pkg holds the phase encodings (NS_GREEN..EW_YELLOW), the four o light patterns, and the counter width constant (8).
REQ-025 One sub-module, traffic_timer, implements the dwell counter: inputs clk, res_n, en, clear, duration; output expire (cnt == duration-1).
REQ-026 traffic_controller holds the phase register, the next-state logic and the output decode.

Verification
REQ-027 Hold res_n=1 for 3 cycles with en=0 -> o=1000 and st=00 throughout, including before the first clock edge.
REQ-028 Release reset, en=1, defaults -> o=1000 for 8 cycles, 0100 for 2, 0010 for 8, 0001 for 2, then 1000 again (20-cycle period).
REQ-029 With LOAD_EN, en=0 and cur_state=01 for one edge, then en=1 -> o=0100 for 2 cycles, then 0010; next_state=01 during the load cycle.
REQ-030 Without LOAD_EN, en=0 for 5 cycles mid-NS_GREEN after 3 counted cycles -> o stays 1000; after en=1, the transition to 0100 occurs after 5 more enabled cycles.
REQ-031 Assert res_n asynchronously between edges during EW_YELLOW -> o becomes 1000 before the next edge, and the dwell restarts at 0.
REQ-032 GREEN_CYCLES=1, YELLOW_CYCLES=1, en=1 -> o steps 1000, 0100, 0010, 0001 on consecutive cycles, and next_state always leads st by one phase.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encodings, light patterns and counter width shared by the traffic controller
package traffic_pkg;
   localparam int CNT_W = 8;
   typedef enum logic [1:0] {
      NS_GREEN  = 2'b00,
      NS_YELLOW = 2'b01,
      EW_GREEN  = 2'b10,
      EW_YELLOW = 2'b11
   } phase_t;
   localparam logic [3:0] LIGHT_NS_GREEN  = 4'b1000;
   localparam logic [3:0] LIGHT_NS_YELLOW = 4'b0100;
   localparam logic [3:0] LIGHT_EW_GREEN  = 4'b0010;
   localparam logic [3:0] LIGHT_EW_YELLOW = 4'b0001;
   function automatic logic [3:0] light(input phase_t p);
      return p == NS_GREEN  ? LIGHT_NS_GREEN  :
             p == NS_YELLOW ? LIGHT_NS_YELLOW :
             p == EW_GREEN  ? LIGHT_EW_GREEN  : LIGHT_EW_YELLOW;
   endfunction
endpackage

// File: rtl/traffic_timer.sv
// traffic_timer: dwell counter for the current phase
//   clk, res_n (async active-high) ; en counts ; clear zeroes the count ;
//   duration = phase length ; expire = last cycle of the phase (cnt == duration-1)
module traffic_timer
   import traffic_pkg::*;
(
   input  logic             clk,
   input  logic             res_n,
   input  logic             en,
   input  logic             clear,
   input  logic [CNT_W-1:0] duration,
   output logic             expire
);
   logic [CNT_W-1:0] cnt;
   assign expire = cnt == duration - 1'b1;
   always_ff @(posedge clk or posedge res_n)
      if (res_n) cnt <= '0;
      else if (clear || (en && expire)) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/traffic_controller.sv
// traffic_controller: four-phase NS/EW traffic light sequencer
//   clk ; res_n async active-high ; en runs phases ; cur_state phase to load while en=0 ;
//   next_state = phase taken at next edge ; o = {NS green, NS yellow, EW green, EW yellow}
//   Define TRAFFIC_CTRL_LOAD_EN to load cur_state (and clear the dwell) on edges with en=0;
//   otherwise en=0 simply holds.
module traffic_controller
   import traffic_pkg::*;
#(
   parameter int GREEN_CYCLES  = 8,
   parameter int YELLOW_CYCLES = 2
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       en,
   input  logic [1:0] cur_state,
   output logic [1:0] next_state,
   output logic [3:0] o
);
   phase_t           st, nxt;
   logic             expire, load;
   logic [1:0]       load_state;
   logic [CNT_W-1:0] duration;
`ifdef TRAFFIC_CTRL_LOAD_EN
   assign load       = ~en;
   assign load_state = cur_state;
`else
   logic [1:0] unused_cur_state;
   assign unused_cur_state = cur_state;
   assign load             = 1'b0;
   assign load_state       = st;
`endif
   // yellow phases have the low encoding bit set
   assign duration = st[0] ? CNT_W'(YELLOW_CYCLES) : CNT_W'(GREEN_CYCLES);
   traffic_timer u_timer (
      .clk      (clk),
      .res_n    (res_n),
      .en       (en),
      .clear    (load),
      .duration (duration),
      .expire   (expire)
   );
   always_comb begin
      nxt = st;
      nxt = en ? (expire ? phase_t'(st + 2'd1) : st) : phase_t'(load_state);
   end
   always_ff @(posedge clk or posedge res_n)
      if (res_n) st <= NS_GREEN;
      else st <= nxt;
   assign next_state = nxt;
   assign o          = light(st);
endmodule

// File: tb/tb_traffic_controller.sv
// tb_traffic_controller: directed scoreboard bench for traffic_controller (default and 1/1 durations)
module tb_traffic_controller;
   logic       clk = 1'b0, res_n = 1'b1, en = 1'b0;
   logic [1:0] cur_state = 2'b00;
   logic [1:0] ns, ns1;
   logic [3:0] o, o1;
   int checks = 0, errors = 0;
   int pos = 0, pos1 = 0;
   typedef struct packed {
      logic [3:0] o;
      logic [1:0] ns;
      logic       c1;
      logic [3:0] o1;
      logic [1:0] ns1;
   } exp_t;
   exp_t sb[$];
   always #5 clk = ~clk;
   traffic_controller dut (
      .clk(clk), .res_n(res_n), .en(en), .cur_state(cur_state), .next_state(ns), .o(o)
   );
   traffic_controller #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1)) dut1 (
      .clk(clk), .res_n(res_n), .en(en), .cur_state(cur_state), .next_state(ns1), .o(o1)
   );
   // position in the 20-cycle default period -> phase
   function automatic logic [1:0] ph(input int m);
      return m < 8 ? 2'd0 : m < 10 ? 2'd1 : m < 18 ? 2'd2 : 2'd3;
   endfunction
   function automatic logic [3:0] lamp(input logic [1:0] p);
      return 4'b1000 >> p;
   endfunction
   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask
   task automatic tick(input string tag, input bit c1);
      exp_t e;
      if (en) pos = (pos + 1) % 20;
      if (en) pos1 = (pos1 + 1) % 4;
      e.o   = lamp(ph(pos));
      e.ns  = en ? ph((pos + 1) % 20) : ph(pos);
      e.c1  = c1;
      e.o1  = lamp(2'(pos1));
      e.ns1 = en ? 2'((pos1 + 1) % 4) : 2'(pos1);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".o"}, o, e.o);
      chk({tag, ".ns"}, {2'b00, ns}, {2'b00, e.ns});
      if (e.c1) begin
         chk({tag, ".o1"}, o1, e.o1);
         chk({tag, ".ns1"}, {2'b00, ns1}, {2'b00, e.ns1});
      end
   endtask
   initial begin
      #1;
      chk("pre_edge.o", o, 4'b1000);
      chk("pre_edge.o1", o1, 4'b1000);
      chk("pre_edge.ns", {2'b00, ns}, 4'b0000);
      for (int i = 0; i < 3; i++) tick("reset_hold", 1'b1);
      @(negedge clk);
      res_n = 1'b0;
      en    = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick("run", i < 8);
         cur_state = 2'($urandom_range(3));
      end
      cur_state = 2'b00;
`ifdef TRAFFIC_CTRL_LOAD_EN
      begin
         exp_t e;
         en        = 1'b0;
         cur_state = 2'b01;
         #1;
         chk("load.ns_pre", {2'b00, ns}, 4'b0001);
         e    = '0;
         e.o  = 4'b0100;
         e.ns = 2'b01;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk("load.o", o, e.o);
         chk("load.ns", {2'b00, ns}, {2'b00, e.ns});
         pos       = 8;
         en        = 1'b1;
         cur_state = 2'b00;
         for (int i = 0; i < 2; i++) tick("after_load", 1'b0);
      end
`else
      for (int i = 0; i < 3; i++) tick("pre_hold", 1'b0);
      en = 1'b0;
      for (int i = 0; i < 5; i++) tick("hold", 1'b0);
      en = 1'b1;
      for (int i = 0; i < 7; i++) tick("resume", 1'b0);
`endif
      for (int i = 0; i < 9; i++) tick("to_ew_yellow", 1'b0);
      #2;
      res_n = 1'b1;
      #1;
      chk("async_reset.o", o, 4'b1000);
      chk("async_reset.ns", {2'b00, ns}, 4'b0000);
      @(negedge clk);
      res_n = 1'b0;
      pos   = 0;
      for (int i = 0; i < 8; i++) tick("restart", 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
